// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register indices, control/status
// bit positions, bus handshake states and a byte-lane mask helper.
package wb_timer_pkg;

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PRESCALE = 3'd1;
   localparam logic [2:0] REG_COUNT    = 3'd2;
   localparam logic [2:0] REG_COMPARE  = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;
   localparam int STATUS_MATCH     = 0;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_t;

   // Expands the four byte enables into a per-bit write mask.
   function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle between the data master and the timer slave.
interface wb_timer_if;

   logic [4:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o
   );

endinterface

// File: rtl/wb_timer_prescaler.sv
// Prescaler for the timer: emits a one-cycle tick every (prescale+1) enabled
// clocks; the count is held at zero while disabled or when cleared.
module wb_timer_prescaler #(
   parameter int PS_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clear,
   input  logic [PS_WIDTH-1:0] prescale,
   output logic                tick
);

   localparam logic [PS_WIDTH-1:0] PS_ONE = PS_WIDTH'(1);

   logic [PS_WIDTH-1:0] ps_cnt_q;
   logic [PS_WIDTH-1:0] ps_cnt_d;

   assign tick = en & (ps_cnt_q == prescale);

   always_comb begin
      ps_cnt_d = ps_cnt_q + PS_ONE;
      if (!en || clear || tick) begin
         ps_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_cnt_q <= '0;
      end else begin
         ps_cnt_q <= ps_cnt_d;
      end
   end

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic timer/compare slave: registered single-cycle ack, byte-lane
// writes, prescaled 32-bit counter with compare match and level interrupt.
module wb_timer
   import wb_timer_pkg::*;
#(
   parameter int PS_WIDTH  = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   wb_timer_if.slave   wb,
   output logic        irq_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   bus_state_t           state_q, state_d;
   logic [2:0]           ctrl_q, ctrl_d;
   logic [PS_WIDTH-1:0]  prescale_q, prescale_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] compare_q, compare_d;
   logic                 match_q, match_d;
   logic [31:0]          dat_o_q, dat_o_d;

   logic                 xfer_commit;
   logic                 wr_commit;
   logic [2:0]           reg_idx;
   logic [31:0]          wr_mask;
   logic [31:0]          rd_data;
   logic                 ps_clear;
   logic                 tick;
   logic                 unused_adr_bits;

   assign reg_idx         = wb.wb_adr_i[4:2];
   assign unused_adr_bits = ^wb.wb_adr_i[1:0];
   assign wr_mask         = sel_to_mask(wb.wb_sel_i);
   assign xfer_commit     = (state_q == BUS_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
   assign wr_commit       = xfer_commit && wb.wb_we_i;
   assign ps_clear        = wr_commit && (reg_idx == REG_PRESCALE);

   assign wb.wb_ack_o = (state_q == BUS_ACK);
   assign wb.wb_dat_o = dat_o_q;
   assign irq_o       = match_q & ctrl_q[CTRL_IRQ_EN];

   wb_timer_prescaler #(
      .PS_WIDTH(PS_WIDTH)
   ) u_prescaler (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_i),
      .en       (ctrl_q[CTRL_EN]),
      .clear    (ps_clear),
      .prescale (prescale_q),
      .tick     (tick)
   );

   // Ack is held for one cycle, so a persistent strobe is served every other cycle.
   always_comb begin
      state_d = BUS_IDLE;
      case (state_q)
         BUS_IDLE: if (wb.wb_cyc_i && wb.wb_stb_i) state_d = BUS_ACK;
         BUS_ACK:  state_d = BUS_IDLE;
         default:  state_d = BUS_IDLE;
      endcase
   end

   always_comb begin
      rd_data = '0;
      case (reg_idx)
         REG_CTRL:     rd_data[2:0]           = ctrl_q;
         REG_PRESCALE: rd_data[PS_WIDTH-1:0]  = prescale_q;
         REG_COUNT:    rd_data[CNT_WIDTH-1:0] = count_q;
         REG_COMPARE:  rd_data[CNT_WIDTH-1:0] = compare_q;
         REG_STATUS:   rd_data[STATUS_MATCH]  = match_q;
         default:      rd_data = '0;
      endcase
      dat_o_d = xfer_commit ? rd_data : dat_o_q;
   end

   // Ordering sets priority: W1C clear, then tick (match set wins), then bus writes (COUNT write wins).
   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      compare_d  = compare_q;
      match_d    = match_q;
      if (wr_commit && (reg_idx == REG_STATUS) &&
          wr_mask[STATUS_MATCH] && wb.wb_dat_i[STATUS_MATCH]) begin
         match_d = 1'b0;
      end
      if (tick) begin
         count_d = count_q + CNT_ONE;
         if (count_q == compare_q) begin
            match_d = 1'b1;
            if (ctrl_q[CTRL_AUTO_RELOAD]) count_d = '0;
         end
      end
      if (wr_commit) begin
         case (reg_idx)
            REG_CTRL:
               ctrl_d = (ctrl_q & ~wr_mask[2:0]) | (wb.wb_dat_i[2:0] & wr_mask[2:0]);
            REG_PRESCALE:
               prescale_d = (prescale_q & ~wr_mask[PS_WIDTH-1:0]) |
                            (wb.wb_dat_i[PS_WIDTH-1:0] & wr_mask[PS_WIDTH-1:0]);
            REG_COUNT:
               count_d = (count_q & ~wr_mask[CNT_WIDTH-1:0]) |
                         (wb.wb_dat_i[CNT_WIDTH-1:0] & wr_mask[CNT_WIDTH-1:0]);
            REG_COMPARE:
               compare_d = (compare_q & ~wr_mask[CNT_WIDTH-1:0]) |
                           (wb.wb_dat_i[CNT_WIDTH-1:0] & wr_mask[CNT_WIDTH-1:0]);
            default: ;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q    <= BUS_IDLE;
         ctrl_q     <= '0;
         prescale_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         match_q    <= 1'b0;
         dat_o_q    <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         match_q    <= match_d;
         dat_o_q    <= dat_o_d;
      end
   end

endmodule
